// File: rtl/mem_controller.sv
// Single-port RAM front end: arbitrates instruction fetches and data loads/stores with fixed LAT.
// Optional MEM_CTRL_MISALIGN_ERR_EN adds derr and answers misaligned data accesses without touching RAM.
module mem_controller #(
  parameter int unsigned LAT    = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              imem_ren,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_load,
  output logic              ihit,
  input  logic              dmem_ren,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [1:0]        dmem_width,
  input  logic [31:0]       dmem_store,
  output logic [31:0]       dmem_load,
  output logic              dhit,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
`ifdef MEM_CTRL_MISALIGN_ERR_EN
  output logic              derr,
`endif
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAT_LAST = 4'(LAT - 1);

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r;
  logic              last_d_r;
  logic              kind_d_r, kind_wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        width_r;
  logic [31:0]       store_r;
  logic              d_pend_s, i_pend_s, grant_any_s, grant_d_s, misalign_s;

  // Sub-word lane offset; misaligned halves/words are aligned down.
  function automatic logic [1:0] lane_off(input logic [1:0] a, input logic [1:0] w);
    case (w)
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] d, input logic [1:0] a,
                                               input logic [1:0] w);
    logic [31:0] sh;
    sh = d >> {lane_off(a, w), 3'b000};
    case (w)
      2'b00:   lane_extract = {24'h000000, sh[7:0]};
      2'b01:   lane_extract = {16'h0000, sh[15:0]};
      default: lane_extract = sh;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] a, input logic [1:0] w);
    case (w)
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] s, input logic [1:0] w);
    case (w)
      2'b00:   store_data = {4{s[7:0]}};
      2'b01:   store_data = {2{s[15:0]}};
      default: store_data = s;
    endcase
  endfunction

  assign d_pend_s    = dmem_ren | dmem_wen;
  assign i_pend_s    = imem_ren;
  assign grant_any_s = d_pend_s | i_pend_s;
  assign grant_d_s   = d_pend_s & (~i_pend_s | ~last_d_r);

`ifdef MEM_CTRL_MISALIGN_ERR_EN
  assign misalign_s = grant_d_s & (((dmem_width == 2'b01) & dmem_addr[0]) |
                                   (dmem_width[1] & (dmem_addr[1:0] != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) state_nxt_s = misalign_s ? RESP : BUSY;
        else             state_nxt_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == LAT_LAST) state_nxt_s = RESP;
        else                   state_nxt_s = BUSY;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request latch, grant history and latency counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_r     <= 4'd0;
      last_d_r  <= 1'b0;
      kind_d_r  <= 1'b0;
      kind_wr_r <= 1'b0;
      addr_r    <= '0;
      width_r   <= 2'b00;
      store_r   <= 32'h0;
    end else if (state_r == IDLE && grant_any_s) begin
      cnt_r     <= 4'd0;
      last_d_r  <= grant_d_s;
      kind_d_r  <= grant_d_s;
      kind_wr_r <= grant_d_s & dmem_wen;
      addr_r    <= grant_d_s ? dmem_addr : imem_addr;
      width_r   <= grant_d_s ? dmem_width : 2'b10;
      store_r   <= dmem_store;
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // Registered completion outputs; load data holds outside completions
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      imem_load <= 32'h0;
      dmem_load <= 32'h0;
`ifdef MEM_CTRL_MISALIGN_ERR_EN
      derr      <= 1'b0;
`endif
    end else begin
      ihit <= (state_r == BUSY) & (state_nxt_s == RESP) & ~kind_d_r;
      dhit <= (state_nxt_s == RESP) & (((state_r == BUSY) & kind_d_r) | (state_r == IDLE));
`ifdef MEM_CTRL_MISALIGN_ERR_EN
      derr <= (state_r == IDLE) & (state_nxt_s == RESP);
`endif
      if (state_r == BUSY && state_nxt_s == RESP) begin
        if (kind_d_r) dmem_load <= kind_wr_r ? 32'h0 : lane_extract(ram_rdata, addr_r[1:0], width_r);
        else          imem_load <= ram_rdata;
      end else if (state_r == IDLE && state_nxt_s == RESP) begin
        dmem_load <= 32'h0;
      end
    end
  end

  // RAM port decode, from the latched request only
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_be    = 4'b0000;
    ram_wdata = 32'h0;
    if (state_r == BUSY) begin
      ram_ren  = ~kind_wr_r;
      ram_wen  = kind_wr_r;
      ram_addr = {addr_r[ADDR_W-1:2], 2'b00};
      if (kind_wr_r) begin
        ram_be    = store_be(addr_r[1:0], width_r);
        ram_wdata = store_data(store_r, width_r);
      end else begin
        ram_be    = 4'b0000;
        ram_wdata = 32'h0;
      end
    end else begin
      ram_ren = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller (LAT=2) with a byte-level reference memory.
module tb_mem_controller;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        imem_ren = 1'b0, dmem_ren = 1'b0, dmem_wen = 1'b0;
  logic [31:0] imem_addr = 32'h0, dmem_addr = 32'h0, dmem_store = 32'h0;
  logic [1:0]  dmem_width = 2'b00;
  logic [31:0] imem_load, dmem_load, ram_addr, ram_wdata, ram_rdata;
  logic        ihit, dhit, ram_ren, ram_wen;
  logic [3:0]  ram_be;
`ifdef MEM_CTRL_MISALIGN_ERR_EN
  logic        derr;
`endif

  mem_controller #(.LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_width(dmem_width),
    .dmem_store(dmem_store), .dmem_load(dmem_load), .dhit(dhit),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata),
`ifdef MEM_CTRL_MISALIGN_ERR_EN
    .derr(derr),
`endif
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: word array with byte enables, preloadable by the bench
  logic [31:0] ram_mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h00;
  logic [31:0] pre_data = 32'h0;
  assign ram_rdata = ram_mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_idx] <= pre_data;
    else if (ram_wen)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // Reference: little-endian byte memory
  logic [7:0] ref_mem [0:1023];

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w);
    int b;
    b = int'(a[9:0]);
    case (w)
      2'b00: return {24'h0, ref_mem[b]};
      2'b01: begin b = b & ~1; return {16'h0, ref_mem[b+1], ref_mem[b]}; end
      default: begin b = b & ~3; return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]}; end
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] s);
    int b;
    b = int'(a[9:0]);
    case (w)
      2'b00: ref_mem[b] = s[7:0];
      2'b01: begin b = b & ~1; ref_mem[b] = s[7:0]; ref_mem[b+1] = s[15:8]; end
      default: begin
        b = b & ~3;
        ref_mem[b] = s[7:0]; ref_mem[b+1] = s[15:8];
        ref_mem[b+2] = s[23:16]; ref_mem[b+3] = s[31:24];
      end
    endcase
  endtask

  task automatic drop_reqs();
    imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
  endtask

  // One access: push expectation, drive, wait (bounded) for the hit, pop and compare
  task automatic issue(input logic is_d, input logic wr, input logic [31:0] a, input logic [1:0] w,
                       input logic [31:0] st, output logic [31:0] got, output logic [3:0] be1,
                       output logic [31:0] wd1, output logic [31:0] ad1);
    exp_t e, p;
    logic err;
    int   en_cnt, lat_exp;
    logic done;
    err = 1'b0;
`ifdef MEM_CTRL_MISALIGN_ERR_EN
    err = is_d && ((w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00));
`endif
    e.is_d = is_d;
    e.err  = err;
    if (!is_d)          e.data = ref_load(a, 2'b10);
    else if (wr || err) e.data = 32'h0;
    else                e.data = ref_load(a, w);
    if (is_d && wr && !err) ref_store(a, w, st);
    sb_q.push_back(e);
    lat_exp = err ? 1 : LAT + 1;
    got = 32'h0; be1 = 4'h0; wd1 = 32'h0; ad1 = 32'h0; en_cnt = 0; done = 1'b0;
    @(posedge clk); #1;
    imem_ren = !is_d; imem_addr = a;
    dmem_ren = is_d && !wr; dmem_wen = is_d && wr;
    dmem_addr = a; dmem_width = w; dmem_store = st;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (ram_ren || ram_wen) en_cnt++;
      if (n == 1) begin be1 = ram_be; wd1 = ram_wdata; ad1 = ram_addr; end
      if (ihit || dhit) begin
        p = sb_q.pop_front();
        done = 1'b1;
        check("hit_kind", {31'h0, dhit}, {31'h0, p.is_d});
        check("hit_excl", {31'h0, ihit & dhit}, 32'h0);
        check("latency", n, lat_exp);
        check("ram_en_cycles", en_cnt, err ? 0 : LAT);
        if (p.is_d) begin got = dmem_load; check("dmem_load", got, p.data); end
        else        begin got = imem_load; check("imem_load", got, p.data); end
`ifdef MEM_CTRL_MISALIGN_ERR_EN
        check("derr", {31'h0, derr}, {31'h0, p.err});
`endif
        drop_reqs();
      end
    end
    if (!done) begin
      check("hit_timeout", 32'h0, 32'h1);
      drop_reqs();
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, wd1, ad1, w;
    logic [3:0]  be1;
    exp_t        p;
    int          hits, prev;
    logic        hit_seen;

    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (i == 64)       w = 32'h00500093;
      else if (i == 128) w = 32'hBEEF1234;
      else               w = $urandom;
      pre_we = 1'b1; pre_idx = i[7:0]; pre_data = w;
      ref_mem[4*i] = w[7:0]; ref_mem[4*i+1] = w[15:8];
      ref_mem[4*i+2] = w[23:16]; ref_mem[4*i+3] = w[31:24];
    end
    @(posedge clk); #1;
    pre_we = 1'b0;

    check("reset_ctrl", {24'h0, ihit, dhit, ram_ren, ram_wen, ram_be}, 32'h0);
    check("reset_ram_addr", ram_addr, 32'h0);
    check("reset_ram_wdata", ram_wdata, 32'h0);
    check("reset_imem_load", imem_load, 32'h0);
    check("reset_dmem_load", dmem_load, 32'h0);
`ifdef MEM_CTRL_MISALIGN_ERR_EN
    check("reset_derr", {31'h0, derr}, 32'h0);
`endif
    @(negedge clk); nrst = 1'b1;

    issue(1'b0, 1'b0, 32'h100, 2'b10, 32'h0, got, be1, wd1, ad1);
    check("fetch_word", got, 32'h00500093);
    issue(1'b1, 1'b0, 32'h202, 2'b01, 32'h0, got, be1, wd1, ad1);
    check("half_load_202", got, 32'h0000BEEF);
    issue(1'b1, 1'b0, 32'h201, 2'b00, 32'h0, got, be1, wd1, ad1);
    check("byte_load_201", got, 32'h00000012);
    issue(1'b1, 1'b1, 32'h203, 2'b00, 32'h000000AB, got, be1, wd1, ad1);
    check("store_ram_addr", ad1, 32'h200);
    check("store_ram_be", {28'h0, be1}, 32'h8);
    check("store_ram_wdata", wd1, 32'hABABABAB);
    check("store_load_zero", got, 32'h0);
    issue(1'b1, 1'b0, 32'h200, 2'b10, 32'h0, got, be1, wd1, ad1);
    check("word_after_store", got, 32'hABEF1234);
    issue(1'b1, 1'b1, 32'h206, 2'b01, 32'h12345566, got, be1, wd1, ad1);
    check("half_store_be", {28'h0, be1}, 32'hC);
    check("half_store_wdata", wd1, 32'h55665566);
    issue(1'b1, 1'b0, 32'h204, 2'b10, 32'h0, got, be1, wd1, ad1);
    issue(1'b1, 1'b0, 32'h301, 2'b10, 32'h0, got, be1, wd1, ad1);
`ifdef MEM_CTRL_MISALIGN_ERR_EN
    check("misalign_load_zero", got, 32'h0);
`else
    check("misalign_aligned_down", got, ref_load(32'h300, 2'b10));
`endif

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      ra = 32'h300 + 32'($urandom_range(0, 63));
      if (i % 5 == 4) issue(1'b0, 1'b0, ra, 2'b10, 32'h0, got, be1, wd1, ad1);
      else issue(1'b1, 1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)), $urandom,
                 got, be1, wd1, ad1);
    end

    // Both sides requesting continuously out of reset: D, I, D, I
    @(negedge clk); nrst = 1'b0;
    imem_ren = 1'b1; imem_addr = 32'h100;
    dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h200; dmem_width = 2'b10;
    for (int k = 0; k < 4; k++) begin
      p.is_d = (k % 2 == 0); p.err = 1'b0;
      p.data = p.is_d ? ref_load(32'h200, 2'b10) : ref_load(32'h100, 2'b10);
      sb_q.push_back(p);
    end
    @(posedge clk); #1; nrst = 1'b1;
    hits = 0; prev = 0;
    for (int n = 0; n < 40 && hits < 4; n++) begin
      @(negedge clk);
      if (ihit || dhit) begin
        p = sb_q.pop_front();
        check("rr_kind", {31'h0, dhit}, {31'h0, p.is_d});
        check("rr_excl", {31'h0, ihit & dhit}, 32'h0);
        check("rr_data", p.is_d ? dmem_load : imem_load, p.data);
        if (hits == 0) check("rr_first", n, LAT + 1);
        else           check("rr_gap", n - prev, LAT + 2);
        prev = n;
        hits++;
      end
    end
    drop_reqs();
    if (hits < 4) begin
      check("rr_timeout", hits, 4);
      sb_q.delete();
    end

    // Reset in the middle of a load aborts it
    @(posedge clk); #1;
    dmem_ren = 1'b1; dmem_addr = 32'h200; dmem_width = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_ren", {31'h0, ram_ren}, 32'h1);
    nrst = 1'b0;
    drop_reqs();
    #1;
    check("abort_ctrl", {24'h0, ihit, dhit, ram_ren, ram_wen, ram_be}, 32'h0);
    check("abort_ram_addr", ram_addr, 32'h0);
    check("abort_loads", imem_load | dmem_load, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; nrst = 1'b1;
    hit_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      hit_seen = hit_seen | ihit | dhit;
    end
    check("abort_no_hit", {31'h0, hit_seen}, 32'h0);
    issue(1'b1, 1'b0, 32'h200, 2'b10, 32'h0, got, be1, wd1, ad1);
    check("reissue_after_abort", got, 32'hABEF1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
